// File: rtl/mem_ctrl_if.sv
// Request/response bus between the datapath (MAR/MDR logic) and mem_ctrl.
// The master is the datapath and the slave is the memory sequencer.
interface mem_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req_rd;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req_rd, req_wr, req_addr, req_wdata,
    input  busy, done, rdata, err
  );

  modport slave (
    input  req_rd, req_wr, req_addr, req_wdata,
    output busy, done, rdata, err
  );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port RAM sequencer: one read or write at a time, hides the RAM's registered-address latency.
// Optional read-back check of every write is built when MEMCTRL_WRITE_VERIFY_EN is defined.
module mem_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              reset_i,
  mem_ctrl_if.slave         bus,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_din_o,
  output logic              ram_en_o,
  input  logic [DATA_W-1:0] ram_dout_i
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_CAP,
`ifdef MEMCTRL_WRITE_VERIFY_EN
    VFY_ADDR,
    VFY_CAP,
`endif
    DONE
  } state_e;

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rdata_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_din_q;
  logic              ram_en_q;
`ifdef MEMCTRL_WRITE_VERIFY_EN
  logic              err_q;
`endif

  // ram_addr_q is only loaded on acceptance so the RAM read address stays stable
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_en_q   <= 1'b0;
`ifdef MEMCTRL_WRITE_VERIFY_EN
      err_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef MEMCTRL_WRITE_VERIFY_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (bus.req_wr) begin
            ram_addr_q <= bus.req_addr;
            ram_din_q  <= bus.req_wdata;
            ram_en_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= WR;
          end else if (bus.req_rd) begin
            ram_addr_q <= bus.req_addr;
            ram_en_q   <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RD_ADDR;
          end
        end
        WR: begin
          ram_en_q <= 1'b0;
`ifdef MEMCTRL_WRITE_VERIFY_EN
          state_q  <= VFY_ADDR;
`else
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
`endif
        end
        RD_ADDR: state_q <= RD_CAP;
        RD_CAP: begin
          rdata_q <= ram_dout_i;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
`ifdef MEMCTRL_WRITE_VERIFY_EN
        VFY_ADDR: state_q <= VFY_CAP;
        VFY_CAP: begin
          err_q   <= (ram_dout_i != ram_din_q);
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.rdata  = rdata_q;
`ifdef MEMCTRL_WRITE_VERIFY_EN
  assign bus.err    = err_q;
`else
  assign bus.err    = 1'b0;
`endif
  assign ram_addr_o = ram_addr_q;
  assign ram_din_o  = ram_din_q;
  assign ram_en_o   = ram_en_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl with a behavioural 512x32 registered-address RAM.
// Expected latencies and err follow MEMCTRL_WRITE_VERIFY_EN when it is defined.
module tb_mem_ctrl;
`ifdef MEMCTRL_WRITE_VERIFY_EN
  localparam int WLAT = 4;
  localparam logic VFY_ERR = 1'b1;
`else
  localparam int WLAT = 2;
  localparam logic VFY_ERR = 1'b0;
`endif
  localparam int RLAT = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          doneCnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [8:0]  ramAddr;
  logic [31:0] ramDin;
  logic        ramEn;
  logic [31:0] ramDout;
  logic [31:0] mem [512];
  logic [8:0]  ramAddrQ = '0;
  logic        forceZero = 1'b0;
  int          cycCnt = 0;
  int          compCnt = 0;
  int          failCnt = 0;
  logic [31:0] expRdata = '0;
  exp_t        expQ [$];

  mem_ctrl_if #(.ADDR_W(9), .DATA_W(32)) bus ();

  mem_ctrl #(.ADDR_W(9), .DATA_W(32)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .bus        (bus),
    .ram_addr_o (ramAddr),
    .ram_din_o  (ramDin),
    .ram_en_o   (ramEn),
    .ram_dout_i (ramDout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCnt <= cycCnt + 1;

  // RAM model: writes on en, always latches the address; forceZero corrupts read-back of 0x030
  always @(posedge clk) begin
    if (ramEn) mem[ramAddr] <= ramDin;
    ramAddrQ <= ramAddr;
  end
  assign ramDout = (forceZero && ramAddrQ == 9'h030) ? 32'h0 : mem[ramAddrQ];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compCnt++;
    if (act !== exp) begin
      failCnt++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycCnt);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected response
  always @(negedge clk) begin
    if (!reset && bus.done === 1'b1) begin
      if (expQ.size() == 0) begin
        compCnt++;
        failCnt++;
        $display("[TB] FAIL spuriousDone: got done=1 expected no response at cycle %0d", cycCnt);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("doneCycle", 64'(cycCnt), 64'(e.doneCnt));
        checkOutput("rdata", 64'(bus.rdata), 64'(e.rdata));
        checkOutput("err", 64'(bus.err), 64'(e.err));
      end
    end
  end

  task automatic applyStimulus(input logic rd, input logic wr, input logic [8:0] addr,
                               input logic [31:0] data, input logic pushExp,
                               input logic [31:0] expR, input logic expE,
                               output int accCnt);
    exp_t e;
    @(negedge clk);
    bus.req_rd    = rd;
    bus.req_wr    = wr;
    bus.req_addr  = addr;
    bus.req_wdata = data;
    @(posedge clk);
    #1;
    accCnt = cycCnt;
    bus.req_rd = 1'b0;
    bus.req_wr = 1'b0;
    if (pushExp) begin
      e.rdata   = expR;
      e.err     = expE;
      e.doneCnt = accCnt + (wr ? WLAT : RLAT) - 1;
      expQ.push_back(e);
    end
  endtask

  task automatic waitIdle();
    int budget = 30;
    while (expQ.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    checkOutput("queueDrain", 64'(expQ.size()), 64'd0);
    expQ.delete();
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    bus.req_rd    = 1'b0;
    bus.req_wr    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("idleBusy", 64'(bus.busy), 64'd0);
      checkOutput("idleDone", 64'(bus.done), 64'd0);
      checkOutput("idleErr", 64'(bus.err), 64'd0);
      checkOutput("idleRdata", 64'(bus.rdata), 64'd0);
      checkOutput("idleRamEn", 64'(ramEn), 64'd0);
      checkOutput("idleRamAddr", 64'(ramAddr), 64'd0);
      checkOutput("idleRamDin", 64'(ramDin), 64'd0);
    end

    // Write then read back 0x005
    applyStimulus(1'b0, 1'b1, 9'h005, 32'hDEADBEEF, 1'b1, expRdata, 1'b0, acc);
    @(negedge clk);
    checkOutput("wrBusy", 64'(bus.busy), 64'd1);
    checkOutput("wrRamEn", 64'(ramEn), 64'd1);
    checkOutput("wrRamAddr", 64'(ramAddr), 64'h005);
    checkOutput("wrRamDin", 64'(ramDin), 64'hDEADBEEF);
    waitIdle();
    applyStimulus(1'b1, 1'b0, 9'h005, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, acc);
    expRdata = 32'hDEADBEEF;
    @(negedge clk);
    checkOutput("rdBusy", 64'(bus.busy), 64'd1);
    checkOutput("rdRamEn", 64'(ramEn), 64'd0);
    waitIdle();

    // Simultaneous read and write: the write wins at the top address
    applyStimulus(1'b1, 1'b1, 9'h1FF, 32'h12345678, 1'b1, expRdata, 1'b0, acc);
    @(negedge clk);
    checkOutput("bothRamEn", 64'(ramEn), 64'd1);
    checkOutput("bothRamAddr", 64'(ramAddr), 64'h1FF);
    waitIdle();
    applyStimulus(1'b1, 1'b0, 9'h1FF, 32'h0, 1'b1, 32'h12345678, 1'b0, acc);
    expRdata = 32'h12345678;
    waitIdle();

    // Read pulsed while a write is busy must be ignored
    applyStimulus(1'b0, 1'b1, 9'h040, 32'hCAFEF00D, 1'b1, expRdata, 1'b0, acc);
    bus.req_rd   = 1'b1;
    bus.req_addr = 9'h010;
    @(posedge clk);
    #1;
    bus.req_rd = 1'b0;
    waitIdle();
    repeat (4) @(negedge clk);
    checkOutput("ignoredRdRdata", 64'(bus.rdata), 64'h12345678);

    // Reset during the WR cycle: no done, but the RAM still commits the write
    applyStimulus(1'b0, 1'b1, 9'h020, 32'hA5A5A5A5, 1'b0, 32'h0, 1'b0, acc);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    expRdata = 32'h0;
    @(negedge clk);
    checkOutput("rstBusy", 64'(bus.busy), 64'd0);
    checkOutput("rstDone", 64'(bus.done), 64'd0);
    checkOutput("rstRdata", 64'(bus.rdata), 64'd0);
    checkOutput("rstRamEn", 64'(ramEn), 64'd0);
    checkOutput("rstRamAddr", 64'(ramAddr), 64'd0);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 9'h020, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0, acc);
    expRdata = 32'hA5A5A5A5;
    waitIdle();

    // Corrupted read-back of 0x030: err only when the verify build is present
    forceZero = 1'b1;
    applyStimulus(1'b0, 1'b1, 9'h030, 32'hFFFFFFFF, 1'b1, expRdata, VFY_ERR, acc);
    waitIdle();
    forceZero = 1'b0;
    @(negedge clk);
    checkOutput("errCleared", 64'(bus.err), 64'd0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
    $finish;
  end
endmodule
